pwm_capture: RTL

Measures an incoming PWM waveform and reports its period and high time in `clk` cycles. It is the receive-side counterpart of the PWM generator. It sits at a board input or on a loopback from the generator, so that duty and period can be checked in-system. A timeout flags a stuck input (constant 0 or 1).

---
 rtl/pwm_capture.sv | 85 ++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time of pwm_in in clk cycles
// and flags an input that stops toggling.
module pwm_capture #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             meas_valid,
    output logic             stuck_o
);

    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state;
    logic             s1, s, s_d;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s   <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s1  <= pwm_in;
            s   <= s1;
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            high_lat   <= '0;
            period_o   <= '0;
            high_o     <= '0;
            meas_valid <= 1'b0;
            stuck_o    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (rise) stuck_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt   <= CNT_W'(1);
                        state <= HIGH;
                    end
                end
                default: begin
                    if (rise) begin
                        period_o   <= cnt;
                        high_o     <= high_lat;
                        meas_valid <= 1'b1;
                        cnt        <= CNT_W'(1);
                        state      <= HIGH;
                    end else if (fall) begin
                        if (state == HIGH) begin
                            high_lat <= cnt;
                            state    <= LOW;
                        end
                        cnt <= cnt + 1'b1;
                    // >= so a fall landing exactly on TIMEOUT cannot let cnt run past it
                    end else if (cnt >= TO) begin
                        stuck_o <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
